// File: rtl/decode_queue_if.sv
// Shared decode types plus the fetch/dispatch handshake interface
// used by decode_queue (optional M extension macro: RV32M_EN).
package decode_queue_pkg;

   typedef enum logic [2:0] {
      ALU    = 3'd0,
      MUL    = 3'd1,
      DIV    = 3'd2,
      BRANCH = 3'd3,
      LOAD   = 3'd4,
      STORE  = 3'd5
   } unit_t;

   typedef enum logic [2:0] {
      BYTE   = 3'd0,
      HALF   = 3'd1,
      WORD   = 3'd2,
      BYTE_U = 3'd4,
      HALF_U = 3'd5
   } ldst_mode_t;

   typedef struct packed {
      unit_t      unit;
      ldst_mode_t rwmm;
      logic [4:0] qj;
      logic [4:0] qk;
      logic [4:0] dest;
      logic [9:0] op;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [31:0] a;
      logic       a_rdy;
      logic       illegal;
   } dec_t;

endpackage

interface decode_queue_if;
   import decode_queue_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;

   logic        out_valid;
   logic        out_ready;
   unit_t       out_unit;
   ldst_mode_t  out_rwmm;
   logic [4:0]  out_Qj;
   logic [4:0]  out_Qk;
   logic [4:0]  out_Dest;
   logic [9:0]  out_Op;
   logic [31:0] out_Vj;
   logic [31:0] out_Vk;
   logic [31:0] out_A;
   logic        out_A_rdy;
   logic        out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_unit, out_rwmm,
      output out_Qj, out_Qk, out_Dest, out_Op,
      output out_Vj, out_Vk, out_A, out_A_rdy, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_unit, out_rwmm,
      input  out_Qj, out_Qk, out_Dest, out_Op,
      input  out_Vj, out_Vk, out_A, out_A_rdy, out_illegal
   );

endinterface

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: raw FIFO plus registered dispatch record.
// Define RV32M_EN to decode MUL/DIV instead of flagging them illegal.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   decode_queue_if.slave    q,
   output logic [CNT_W-1:0] occupancy
);

   localparam int PW = $clog2(DEPTH);

   localparam dec_t REC_RST = '{
      unit: ALU, rwmm: BYTE,
      qj: 5'd0, qk: 5'd0, dest: 5'd0, op: 10'd0,
      vj: 32'd0, vk: 32'd0, a: 32'd0,
      a_rdy: 1'b1, illegal: 1'b0
   };

   logic [31:0]    instr_mem [DEPTH];
   logic [31:0]    pc_mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CNT_W-1:0] count;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           out_valid_q;
   dec_t           rec_q;
   dec_t           dec;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign q.in_ready = !full && !flush;
   assign push = q.in_valid && q.in_ready;
   assign pop  = !empty && (!out_valid_q || q.out_ready);
   assign occupancy = count;

   // Raw beat storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= q.in_instr;
         pc_mem[wr_ptr]    <= q.in_pc;
      end
   end

   // FIFO pointers and occupancy; flush squashes like reset
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   logic [31:0] ins;
   logic [31:0] pc;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;
   logic        is_op_imm, is_lui, is_auipc, is_op;
   logic        is_jal, is_jalr, is_br, is_ld;
   logic        is_st, is_fence, is_sys, op_base;
`ifdef RV32M_EN
   logic        op_m;
`endif

   assign ins = instr_mem[rd_ptr];
   assign pc  = pc_mem[rd_ptr];
   assign rs1 = ins[19:15];
   assign rs2 = ins[24:20];
   assign rd  = ins[11:7];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'd0};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};

   assign legal     = (ins[1:0] == 2'b11);
   assign is_op_imm = legal && ins[6:2] == 5'b00100;
   assign is_lui    = legal && ins[6:2] == 5'b01101;
   assign is_auipc  = legal && ins[6:2] == 5'b00101;
   assign is_op     = legal && ins[6:2] == 5'b01100;
   assign is_jal    = legal && ins[6:2] == 5'b11011;
   assign is_jalr   = legal && ins[6:2] == 5'b11001;
   assign is_br     = legal && ins[6:2] == 5'b11000;
   assign is_ld     = legal && ins[6:2] == 5'b00000;
   assign is_st     = legal && ins[6:2] == 5'b01000;
   assign is_fence  = legal && ins[6:2] == 5'b00011;
   assign is_sys    = legal && ins[6:2] == 5'b11100;
   assign op_base   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
`ifdef RV32M_EN
   assign op_m      = (f7 == 7'b0000001);
`endif

   // Decode the FIFO head into a dispatch record
   always_comb begin
      dec = REC_RST;
      unique case (1'b1)
         is_op_imm: begin
            dec.op   = {f3, (f3 == 3'b101) ? f7 : 7'd0};
            dec.qj   = rs1;
            dec.vk   = imm_i;
            dec.dest = rd;
         end
         is_lui: begin
            dec.vk   = imm_u;
            dec.dest = rd;
         end
         is_auipc: begin
            dec.vj   = pc;
            dec.vk   = imm_u;
            dec.dest = rd;
         end
         is_op && op_base: begin
            dec.op   = {f3, f7};
            dec.qj   = rs1;
            dec.qk   = rs2;
            dec.dest = rd;
         end
`ifdef RV32M_EN
         is_op && op_m: begin
            dec.unit = f3[2] ? DIV : MUL;
            dec.op   = {f3, 7'b0000001};
            dec.qj   = rs1;
            dec.qk   = rs2;
            dec.dest = rd;
         end
`endif
         is_jal: begin
            dec.unit = BRANCH;
            dec.a    = pc + imm_j;
            dec.dest = rd;
         end
         is_jalr: begin
            dec.unit  = BRANCH;
            dec.op    = {f3, 7'd0};
            dec.qj    = rs1;
            dec.qk    = rs1;
            dec.a     = imm_i;
            dec.a_rdy = 1'b0;
            dec.dest  = rd;
         end
         is_br: begin
            dec.unit = BRANCH;
            dec.op   = {f3, 7'd0};
            dec.qj   = rs1;
            dec.qk   = rs2;
            dec.a    = pc + imm_b;
         end
         is_ld: begin
            dec.unit  = LOAD;
            dec.op    = {f3, 7'd0};
            dec.qj    = rs1;
            dec.a     = imm_i;
            dec.a_rdy = 1'b0;
            dec.dest  = rd;
            dec.rwmm  = ldst_mode_t'(f3);
         end
         is_st: begin
            dec.unit  = STORE;
            dec.op    = {f3, 7'd0};
            dec.qj    = rs1;
            dec.qk    = rs2;
            dec.a     = imm_s;
            dec.a_rdy = 1'b0;
            dec.rwmm  = ldst_mode_t'(f3);
         end
         is_fence: begin
            dec.op = {f3, 7'd0};
            dec.qj = rs1;
         end
         is_sys: begin
            dec.op = {f3, 7'd0};
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Output register: load on pop, hold under backpressure
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         out_valid_q <= 1'b0;
         rec_q       <= REC_RST;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         rec_q       <= dec;
      end else if (q.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign q.out_valid   = out_valid_q;
   assign q.out_unit    = rec_q.unit;
   assign q.out_rwmm    = rec_q.rwmm;
   assign q.out_Qj      = rec_q.qj;
   assign q.out_Qk      = rec_q.qk;
   assign q.out_Dest    = rec_q.dest;
   assign q.out_Op      = rec_q.op;
   assign q.out_Vj      = rec_q.vj;
   assign q.out_Vk      = rec_q.vk;
   assign q.out_A       = rec_q.a;
   assign q.out_A_rdy   = rec_q.a_rdy;
   assign q.out_illegal = rec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4).
// Honors RV32M_EN for the MUL encoding expectations.
module tb_decode_queue;
   import decode_queue_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [2:0] occupancy;
   int         total = 0;
   int         bad = 0;

   decode_queue_if dq();

   decode_queue #(.DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .q(dq.slave),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   logic [128:0] got;
   assign got = {dq.out_unit, dq.out_rwmm, dq.out_Qj, dq.out_Qk,
                 dq.out_Dest, dq.out_Op, dq.out_Vj, dq.out_Vk,
                 dq.out_A, dq.out_A_rdy, dq.out_illegal};

   function automatic logic [128:0] rec(
      input logic [2:0] u, input logic [2:0] m,
      input logic [4:0] qj, input logic [4:0] qk,
      input logic [4:0] d, input logic [9:0] op,
      input logic [31:0] vj, input logic [31:0] vk,
      input logic [31:0] a, input logic ar, input logic il);
      return {u, m, qj, qk, d, op, vj, vk, a, ar, il};
   endfunction

   function automatic logic [31:0] addi_x0(input int k);
      logic [11:0] imm;
      logic [4:0]  r;
      imm = 12'(k);
      r   = 5'(k);
      return {imm, 5'd0, 3'd0, r, 7'b0010011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      dq.in_valid = 1'b0;
      dq.in_instr = '0;
      dq.in_pc = '0;
      dq.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (dq.out_valid !== 1'b0 || occupancy !== 3'd0 || dq.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ctl got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1",
                  dq.out_valid, occupancy, dq.in_ready);
      end
      total++;
      if (got !== rec(ALU, BYTE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL reset_rec got=%h", got);
      end
   endtask

   task automatic test_addi();
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = 32'h00510093;
      dq.in_pc = 32'h100;
      tick();
      dq.in_valid = 1'b0;
      total++;
      if (dq.out_valid !== 1'b0 || occupancy !== 3'd1) begin
         bad++;
         $display("FAIL addi_lat1 got v=%b occ=%0d exp v=0 occ=1",
                  dq.out_valid, occupancy);
      end
      tick();
      total++;
      if (dq.out_valid !== 1'b1 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL addi_lat2 got v=%b occ=%0d exp v=1 occ=0",
                  dq.out_valid, occupancy);
      end
      total++;
      if (got !== rec(ALU, BYTE, 2, 0, 1, 0, 0, 5, 0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL addi_rec got=%h", got);
      end
      tick();
      total++;
      if (dq.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL addi_drain got v=%b exp v=0", dq.out_valid);
      end
   endtask

   task automatic test_branch();
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = 32'h008000EF;
      dq.in_pc = 32'h200;
      tick();
      dq.in_instr = 32'hFE0008E3;
      dq.in_pc = 32'h300;
      tick();
      dq.in_valid = 1'b0;
      total++;
      if (got !== rec(BRANCH, BYTE, 0, 0, 1, 0, 0, 0, 32'h208, 1'b1, 1'b0)
          || dq.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL jal_rec got=%h v=%b", got, dq.out_valid);
      end
      total++;
      if (occupancy !== 3'd1) begin
         bad++;
         $display("FAIL push_pop_occ got=%0d exp=1", occupancy);
      end
      tick();
      total++;
      if (got !== rec(BRANCH, BYTE, 0, 0, 0, 0, 0, 0, 32'h2F0, 1'b1, 1'b0)
          || dq.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL beq_rec got=%h v=%b", got, dq.out_valid);
      end
      tick();
   endtask

   task automatic test_load_store();
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = 32'hFFC12183;
      dq.in_pc = 32'h400;
      tick();
      dq.in_instr = {7'd0, 5'd5, 5'd2, 3'b010, 5'd8, 7'b0100011};
      tick();
      dq.in_valid = 1'b0;
      total++;
      if (got !== rec(LOAD, WORD, 2, 0, 3, 10'h100, 0, 0, 32'hFFFFFFFC, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL lw_rec got=%h", got);
      end
      tick();
      total++;
      if (got !== rec(STORE, WORD, 2, 5, 0, 10'h100, 0, 0, 32'h8, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL sw_rec got=%h", got);
      end
      tick();
   endtask

   task automatic test_mul();
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = 32'h022081B3;
      dq.in_pc = 32'h500;
      tick();
      dq.in_valid = 1'b0;
      tick();
      total++;
`ifdef RV32M_EN
      if (got !== rec(MUL, BYTE, 1, 2, 3, 10'b000_0000001, 0, 0, 0, 1'b1, 1'b0)) begin
`else
      if (got !== rec(ALU, BYTE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1)) begin
`endif
         bad++;
         $display("FAIL mul_rec got=%h", got);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int acc;
      acc = 0;
      dq.out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         dq.in_valid = 1'b1;
         dq.in_instr = addi_x0(i);
         dq.in_pc = 32'(i * 4);
         if (dq.in_ready) acc++;
         tick();
      end
      dq.in_valid = 1'b0;
      total++;
      if (acc !== 5 || occupancy !== 3'd4 || dq.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_fill got acc=%0d occ=%0d rdy=%b exp 5 4 0",
                  acc, occupancy, dq.in_ready);
      end
      dq.out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         total++;
         if (dq.out_valid !== 1'b1 ||
             got !== rec(ALU, BYTE, 0, 0, 5'(k), 0, 0, 32'(k), 0, 1'b1, 1'b0)) begin
            bad++;
            $display("FAIL bp_order_%0d got=%h v=%b", k, got, dq.out_valid);
         end
         tick();
         if (k == 1) begin
            total++;
            if (dq.in_ready !== 1'b1 || occupancy !== 3'd3) begin
               bad++;
               $display("FAIL bp_ready got rdy=%b occ=%0d exp 1 3",
                        dq.in_ready, occupancy);
            end
         end
      end
      total++;
      if (dq.out_valid !== 1'b0 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL bp_empty got v=%b occ=%0d", dq.out_valid, occupancy);
      end
   endtask

   task automatic test_flush();
      dq.out_ready = 1'b0;
      for (int i = 11; i <= 14; i++) begin
         dq.in_valid = 1'b1;
         dq.in_instr = addi_x0(i);
         tick();
      end
      total++;
      if (occupancy !== 3'd3 || dq.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL fl_pre got occ=%0d v=%b exp 3 1", occupancy, dq.out_valid);
      end
      flush = 1'b1;
      dq.in_instr = addi_x0(20);
      #1;
      total++;
      if (dq.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL fl_ready got=%b exp=0", dq.in_ready);
      end
      tick();
      flush = 1'b0;
      dq.in_valid = 1'b0;
      total++;
      if (dq.out_valid !== 1'b0 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL fl_clear got v=%b occ=%0d", dq.out_valid, occupancy);
      end
      tick();
      total++;
      if (dq.out_valid !== 1'b0 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL fl_noaccept got v=%b occ=%0d", dq.out_valid, occupancy);
      end
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = addi_x0(21);
      tick();
      dq.in_valid = 1'b0;
      tick();
      total++;
      if (dq.out_valid !== 1'b1 ||
          got !== rec(ALU, BYTE, 0, 0, 21, 0, 0, 21, 0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL fl_after got=%h v=%b", got, dq.out_valid);
      end
      tick();
   endtask

   task automatic test_illegal();
      dq.out_ready = 1'b1;
      dq.in_valid = 1'b1;
      dq.in_instr = 32'h0000007F;
      tick();
      dq.in_instr = 32'h00510091;
      tick();
      total++;
      if (dq.out_valid !== 1'b1 ||
          got !== rec(ALU, BYTE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1)) begin
         bad++;
         $display("FAIL ill_opc got=%h v=%b", got, dq.out_valid);
      end
      dq.in_instr = addi_x0(7);
      tick();
      dq.in_valid = 1'b0;
      total++;
      if (got !== rec(ALU, BYTE, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1)) begin
         bad++;
         $display("FAIL ill_lowbits got=%h", got);
      end
      tick();
      total++;
      if (dq.out_valid !== 1'b1 ||
          got !== rec(ALU, BYTE, 0, 0, 7, 0, 0, 7, 0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL ill_next got=%h v=%b", got, dq.out_valid);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_load_store();
      test_mul();
      test_backpressure();
      test_flush();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
